// File: rtl/fpu_f2i_arb.sv
// Round-robin arbiter that shares one float-to-integer converter among NUM_REQ requesters.
// Optional watchdog on the converter handshake: define FPU_F2I_ARB_TIMEOUT_EN.
module fpu_f2i_arb #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  busy,
    output logic [31:0]           cvt_din,
    output logic                  cvt_dval,
    input  logic [31:0]           cvt_result,
    input  logic                  cvt_rdy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("fpu_f2i_arb: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W:0]     cand;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic [31:0]        win_data;
    logic [31:0]        data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[32*i +: 32];
    end

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!found && req_valid[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
        grant[win_idx] = found;
    end

    assign win_data  = data_arr[win_idx];
    assign rr_next   = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    assign req_ready = (state == IDLE) ? grant : '0;

`ifdef FPU_F2I_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] watchdog;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            cvt_dval   <= 1'b0;
            cvt_din    <= '0;
            busy       <= 1'b0;
`ifdef FPU_F2I_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
            watchdog   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cvt_din  <= win_data;
                        cvt_dval <= 1'b1;
                        owner    <= win_idx;
                        rr_ptr   <= rr_next;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cvt_dval <= 1'b0;
                    state    <= WAIT;
`ifdef FPU_F2I_ARB_TIMEOUT_EN
                    watchdog <= '0;
`endif
                end
                WAIT: begin
                    if (cvt_rdy) begin
                        resp_data  <= cvt_result;
                        resp_valid <= NUM_REQ'(1) << owner;
                        state      <= RESP;
`ifdef FPU_F2I_ARB_TIMEOUT_EN
                    // Converter never answered: return the integer-indefinite value flagged as error.
                    end else if (watchdog == WD_W'(TIMEOUT_CYC - 1)) begin
                        resp_data  <= 32'h8000_0000;
                        resp_err   <= 1'b1;
                        resp_valid <= NUM_REQ'(1) << owner;
                        state      <= RESP;
                    end else begin
                        watchdog   <= watchdog + 1'b1;
`endif
                    end
                end
                RESP: begin
                    resp_valid <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
`ifdef FPU_F2I_ARB_TIMEOUT_EN
                    resp_err   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_f2i_arb.sv
// Bench for fpu_f2i_arb: behavioural converter stub plus a round-robin order model.
module tb_fpu_f2i_arb;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [31:0]  resp_data;
    logic         resp_err;
    logic         busy;
    logic [31:0]  cvt_din;
    logic         cvt_dval;
    logic [31:0]  cvt_result;
    logic         cvt_rdy;

    logic         stub_rdy, spur_rdy;
    logic [31:0]  stub_res, spur_res;
    int           stub_lat  = 0;
    bit           stub_mute = 1'b0;

    int           tests = 0;
    int           fails = 0;
    int           model_ptr = 0;
    logic [31:0]  dat [4];
    logic [31:0]  rdq [$];

    assign cvt_rdy    = stub_rdy | spur_rdy;
    assign cvt_result = spur_rdy ? spur_res : stub_res;

    always #5 clk = ~clk;

    fpu_f2i_arb #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy), .cvt_din(cvt_din), .cvt_dval(cvt_dval),
        .cvt_result(cvt_result), .cvt_rdy(cvt_rdy)
    );

    // Truncating float-to-int32; out-of-range gives the integer-indefinite value.
    function automatic logic [31:0] f2i(input logic [31:0] x);
        int          e;
        longint      mag;
        logic [23:0] m;
        e = int'(x[30:23]) - 127;
        m = {1'b1, x[22:0]};
        if (e < 0) return 32'h0;
        if (e >= 31) return 32'h8000_0000;
        mag = (e >= 23) ? (longint'(m) << (e - 23)) : (longint'(m) >> (23 - e));
        if (x[31]) mag = -mag;
        return mag[31:0];
    endfunction

    function automatic logic [31:0] rand_f();
        return {1'($urandom), 8'($urandom_range(110, 160)), 23'($urandom)};
    endfunction

    // Converter stub: answers each dval after 4..34 cycles unless reset intervenes.
    logic [31:0] stub_din;
    int          stub_n;
    bit          stub_abort;
    always begin
        @(negedge clk);
        if (cvt_dval && rst_n && !stub_mute) begin
            stub_din   = cvt_din;
            stub_n     = (stub_lat != 0) ? stub_lat : int'($urandom_range(4, 34));
            stub_abort = 1'b0;
            for (int c = 1; c < stub_n; c++) begin
                @(negedge clk);
                if (!rst_n) stub_abort = 1'b1;
            end
            if (!stub_abort) begin
                @(posedge clk); #1;
                stub_res = f2i(stub_din);
                stub_rdy = 1'b1;
                @(posedge clk); #1;
                stub_rdy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pack_data();
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = dat[i];
    endtask

    task automatic watch(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (resp_valid != 4'b0) seen++;
        end
    endtask

    // Raise mask, expect `total` grants in rotating order; persist re-requests after each grant.
    task automatic serve(input logic [3:0] mask, input int total, input bit persist);
        int          ord [$];
        logic [31:0] gd [$];
        int          p, ngrant, nresp, ndval, cyc, cur, budget;
        bit          upd, hit;
        logic [3:0]  g, drop;
        p = model_ptr; ngrant = 0; nresp = 0; ndval = 0; cyc = 0; cur = 0;
        budget = total * 45 + 20;
        for (int n = 0; n < total; n++) begin
            hit = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!hit && mask[(p + k) % 4]) begin
                    hit = 1'b1;
                    ord.push_back((p + k) % 4);
                end
            end
            p = (ord[n] + 1) % 4;
        end
        rdq.delete();
        tick();
        pack_data();
        req_valid = mask;
        while (nresp < total && cyc < budget) begin
            @(negedge clk);
            cyc++;
            g = req_valid & req_ready;
            drop = 4'b0;
            upd = 1'b0;
            if (cvt_dval) begin
                ndval++;
                chk("cvt_din", cvt_din, (gd.size() > 0) ? gd[gd.size()-1] : 32'hDEAD_BEEF);
            end
            if (g != 4'b0) begin
                chk("grant_after_resp", ngrant, nresp);
                for (int k = 0; k < 4; k++) if (g[k]) cur = k;
                chk("grant_order", {28'b0, g}, (ngrant < total) ? (32'd1 << ord[ngrant]) : 32'd0);
                gd.push_back(dat[cur]);
                ngrant++;
                if (persist && ngrant < total) begin
                    dat[cur] = rand_f();
                    upd = 1'b1;
                end else begin
                    drop = g;
                end
            end
            if (resp_valid != 4'b0) begin
                chk("busy_in_resp", busy, 1);
                chk("resp_owner", {28'b0, resp_valid}, (nresp < total) ? (32'd1 << ord[nresp]) : 32'd0);
                chk("resp_data", resp_data, (nresp < gd.size()) ? f2i(gd[nresp]) : 32'hDEAD_BEEF);
                chk("resp_err", resp_err, 0);
                rdq.push_back(resp_data);
                nresp++;
            end
            tick();
            req_valid = req_valid & ~drop;
            if (upd) pack_data();
            if (nresp >= total) req_valid = 4'b0;
        end
        req_valid = 4'b0;
        chk("served_all", nresp, total);
        chk("dval_per_grant", ndval, ngrant);
        model_ptr = p;
        @(negedge clk);
        chk("busy_after_resp", busy, 0);
        chk("resp_one_cycle", {28'b0, resp_valid}, 0);
    endtask

    task automatic one_req(input string tag, input int i, input logic [31:0] d, input logic [31:0] exp);
        dat[i] = d;
        serve(4'b1 << i, 1, 1'b0);
        chk(tag, (rdq.size() > 0) ? rdq[0] : 32'hDEAD_BEEF, exp);
    endtask

    initial begin
        int         seen, cyc, total;
        bit         got;
        logic [3:0] m;
        bit         pers;

        rst_n = 1'b0; req_valid = '0; req_data = '0;
        spur_rdy = 1'b0; spur_res = '0; stub_rdy = 1'b0; stub_res = '0;
        for (int i = 0; i < 4; i++) dat[i] = rand_f();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_req_ready", {28'b0, req_ready}, 0);
        chk("rst_resp_valid", {28'b0, resp_valid}, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cvt_dval", cvt_dval, 0);
        chk("rst_cvt_din", cvt_din, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_ptr = 0;

        // All four held from reset: 0,1,2,3,0.
        serve(4'b1111, 5, 1'b1);

        one_req("one_point_five", 0, 32'h3FC0_0000, 32'h0000_0001);
        one_req("neg_two",        2, 32'hC000_0000, 32'hFFFF_FFFE);
        one_req("overflow",       1, 32'h4F80_0000, 32'h8000_0000);
        one_req("zero",           3, 32'h0000_0000, 32'h0000_0000);

        // Stray converter done pulse while idle.
        tick();
        spur_res = 32'h0000_3039;
        spur_rdy = 1'b1;
        tick();
        spur_rdy = 1'b0;
        watch(6, seen);
        chk("spurious_rdy_idle", seen, 0);
        chk("spurious_busy", busy, 0);

        repeat (12) begin
            m     = 4'($urandom_range(1, 15));
            pers  = 1'($urandom);
            total = pers ? int'($urandom_range(1, 6)) : $countones(m);
            for (int i = 0; i < 4; i++) dat[i] = rand_f();
            serve(m, total, pers);
        end

        // Reset during WAIT drops the conversion and rewinds the pointer.
        stub_lat = 30;
        tick();
        dat[1] = 32'h3F80_0000;
        pack_data();
        req_valid = 4'b0010;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 4'b0) got = 1'b1;
        end
        chk("mid_grant", got, 1);
        tick();
        req_valid = 4'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_ptr = 0;
        watch(45, seen);
        chk("mid_reset_no_resp", seen, 0);
        chk("mid_reset_busy", busy, 0);
        stub_lat = 0;
        dat[1] = 32'h4228_0000;
        dat[3] = rand_f();
        serve(4'b1010, 2, 1'b0);
        chk("post_reset_42", (rdq.size() > 0) ? rdq[0] : 32'hDEAD_BEEF, 32'h0000_002A);

`ifdef FPU_F2I_ARB_TIMEOUT_EN
        stub_mute = 1'b1;
        tick();
        dat[0] = 32'h3F80_0000;
        pack_data();
        req_valid = 4'b0001;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 4'b0) got = 1'b1;
        end
        chk("to_grant", got, 1);
        tick();
        req_valid = 4'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < TIMEOUT_CYC + 20) begin
            @(negedge clk);
            cyc++;
            if (resp_valid != 4'b0) got = 1'b1;
        end
        chk("to_latency", cyc, TIMEOUT_CYC + 2);
        chk("to_resp_valid", {28'b0, resp_valid}, 32'h1);
        chk("to_resp_data", resp_data, 32'h8000_0000);
        chk("to_resp_err", resp_err, 1);
        @(negedge clk);
        chk("to_err_clear", resp_err, 0);
        chk("to_busy_clear", busy, 0);
        tick();
        spur_res = 32'h0000_0001;
        spur_rdy = 1'b1;
        tick();
        spur_rdy = 1'b0;
        watch(6, seen);
        chk("to_late_rdy", seen, 0);
        stub_mute = 1'b0;
        model_ptr = 1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
